// File: rtl/timing_480p_if.sv
// Video timing bundle between the 640x480 timing generator and its consumers.
// The master is the timing generator; the slave is the painter or encoder side.
interface timing_480p_if;
  logic        en;
  logic [9:0]  sx;
  logic [9:0]  sy;
  logic        de;
  logic        hsync;
  logic        vsync;
  logic        line;
  logic        frame;
  logic        de_d;
  logic        hsync_d;
  logic        vsync_d;
  logic [15:0] frame_cnt;

  modport master (
    input  en,
    output sx, sy, de, hsync, vsync, line, frame,
    output de_d, hsync_d, vsync_d, frame_cnt
  );

  modport slave (
    output en,
    input  sx, sy, de, hsync, vsync, line, frame,
    input  de_d, hsync_d, vsync_d, frame_cnt
  );
endinterface

// File: rtl/timing_480p.sv
// 640x480@60 raster timing generator with registered decodes and a sync/DE delay line.
// Optional frame counter is built only when TIMING_480P_FRAME_CNT_EN is defined.
module timing_480p #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int PIPE_DLY = 1
) (
  input  logic          clk_pix,
  input  logic          rst_n,
  timing_480p_if.master vid
);

  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_BEG = H_ACTIVE + H_FP;
  localparam int H_SYNC_END = H_ACTIVE + H_FP + H_SYNC;
  localparam int V_SYNC_BEG = V_ACTIVE + V_FP;
  localparam int V_SYNC_END = V_ACTIVE + V_FP + V_SYNC;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  if (H_TOTAL > 1024) begin : g_bad_h_total
    $error("timing_480p: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > 1024) begin : g_bad_v_total
    $error("timing_480p: V_TOTAL exceeds 1024");
  end
  if ((PIPE_DLY < 0) || (PIPE_DLY > 4)) begin : g_bad_pipe_dly
    $error("timing_480p: PIPE_DLY must be 0..4");
  end

  logic [9:0] sx_q, sy_q;
  logic [9:0] sx_nxt, sy_nxt;
  logic       de_q, hs_q, vs_q, line_q, frame_q;
  logic       de_nxt, hs_nxt, vs_nxt, line_nxt, frame_nxt;

  // Decodes come from the next counter values so that, once registered,
  // they line up with the sx/sy presented in the same cycle.
  always_comb begin
    sx_nxt = sx_q + 10'd1;
    sy_nxt = sy_q;
    if (sx_q == H_LAST) begin
      sx_nxt = '0;
      sy_nxt = (sy_q == V_LAST) ? '0 : sy_q + 10'd1;
    end
    de_nxt    = (int'(sx_nxt) < H_ACTIVE) && (int'(sy_nxt) < V_ACTIVE);
    hs_nxt    = ((int'(sx_nxt) >= H_SYNC_BEG) && (int'(sx_nxt) < H_SYNC_END))
                ? SYNC_POL : ~SYNC_POL;
    vs_nxt    = ((int'(sy_nxt) >= V_SYNC_BEG) && (int'(sy_nxt) < V_SYNC_END))
                ? SYNC_POL : ~SYNC_POL;
    line_nxt  = (sx_nxt == '0);
    frame_nxt = (sx_nxt == '0) && (sy_nxt == '0);
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      sx_q    <= H_LAST;
      sy_q    <= V_LAST;
      de_q    <= 1'b0;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else if (vid.en) begin
      sx_q    <= sx_nxt;
      sy_q    <= sy_nxt;
      de_q    <= de_nxt;
      hs_q    <= hs_nxt;
      vs_q    <= vs_nxt;
      line_q  <= line_nxt;
      frame_q <= frame_nxt;
    end
  end

  assign vid.sx    = sx_q;
  assign vid.sy    = sy_q;
  assign vid.de    = de_q;
  assign vid.hsync = hs_q;
  assign vid.vsync = vs_q;
  assign vid.line  = line_q;
  assign vid.frame = frame_q;

  // Delay line advances only with en so it stays coherent with a painter
  // that stalls on the same enable.
  if (PIPE_DLY == 0) begin : g_no_dly
    assign vid.de_d    = de_q;
    assign vid.hsync_d = hs_q;
    assign vid.vsync_d = vs_q;
  end else begin : g_dly
    logic [2:0] pipe [PIPE_DLY];

    always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < PIPE_DLY; i++) begin
          pipe[i] <= {1'b0, ~SYNC_POL, ~SYNC_POL};
        end
      end else if (vid.en) begin
        pipe[0] <= {de_q, hs_q, vs_q};
        for (int i = 1; i < PIPE_DLY; i++) begin
          pipe[i] <= pipe[i-1];
        end
      end
    end

    assign {vid.de_d, vid.hsync_d, vid.vsync_d} = pipe[PIPE_DLY-1];
  end

`ifdef TIMING_480P_FRAME_CNT_EN
  logic [15:0] fcnt_q;

  // Counts on the edge that presents frame=1, so the first frame reads 1.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
    end else if (vid.en && frame_nxt) begin
      fcnt_q <= fcnt_q + 16'd1;
    end
  end

  assign vid.frame_cnt = fcnt_q;
`else
  assign vid.frame_cnt = '0;
`endif

endmodule

// File: doc/timing_480p.md
Name: timing_480p

Overview:
- Video timing generator for the 640x480@60 HDMI test path.
- Produces the raster coordinates sx/sy consumed by the pixel painter, plus hsync/vsync/data-enable and frame/line strobes.
- Provides sync/DE copies delayed by a configurable number of pixel clocks so they line up with the painter's registered RGB at the TMDS encoder.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync asserted level (0 = active-low, 1 = active-high)
- PIPE_DLY, 1, delay in clk_pix cycles applied to de_d/hsync_d/vsync_d; legal 0..4

Ports:
- clk_pix  input  1  pixel clock (25.175 MHz nominal)
- rst_n  input  1  asynchronous active-low reset
- en  input  1  count enable; low freezes all state
- sx  output  10  horizontal position, 0..H_TOTAL-1
- sy  output  10  vertical position, 0..V_TOTAL-1
- de  output  1  high when sx<H_ACTIVE and sy<V_ACTIVE
- hsync  output  1  horizontal sync at SYNC_POL level during the sync window
- vsync  output  1  vertical sync at SYNC_POL level during the sync window
- line  output  1  one-clock strobe when sx==0
- frame  output  1  one-clock strobe when sx==0 and sy==0
- de_d  output  1  de delayed by PIPE_DLY clocks
- hsync_d  output  1  hsync delayed by PIPE_DLY clocks
- vsync_d  output  1  vsync delayed by PIPE_DLY clocks
- frame_cnt  output  16  frame counter (see Optional Feature)

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525. Both must be ≤1024; elaboration-time check fails otherwise. PIPE_DLY>4 is also an elaboration error.
- Reset (async assert, synchronous release via clk_pix edge):
  - sx=H_TOTAL-1 (799), sy=V_TOTAL-1 (524).
  - de=0, hsync=vsync=~SYNC_POL, line=0, frame=0.
  - All delay-line stages = {de=0, syncs inactive}; frame_cnt=0.
- First enabled edge after release: sx=0, sy=0, de=1, line=1, frame=1.
- Counter advance (en=1):
  - sx increments by 1.
  - When sx==H_TOTAL-1: sx←0 and sy increments.
  - When sy==V_TOTAL-1 at the same wrap: sy←0.
- All decoded outputs (de, hsync, vsync, line, frame) are registered. Each is computed from the next counter values, so each is always consistent with the sx/sy presented in the same cycle. There is zero latency between sx/sy and these decodes.
- Sync windows:
  - hsync active for H_ACTIVE+H_FP ≤ sx < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync active for V_ACTIVE+V_FP ≤ sy < V_ACTIVE+V_FP+V_SYNC (490..491), over full lines (aligned to sx=0).
- en=0: sx, sy and all decodes hold. The delay line also holds, so the pipeline stays coherent with a painter clocked identically. frame_cnt holds.
- Delay line: shift register of depth PIPE_DLY on {de, hsync, vsync}, advancing only when en=1. With PIPE_DLY=0, *_d equal the undelayed outputs combinationally.
- Reset asserted mid-frame: immediate return to reset values; no partial-line completion.

Optional Feature:
- Macro: TIMING_480P_FRAME_CNT_EN.
- Defined: frame_cnt is a 16-bit counter that increments in the same cycle frame=1 is presented (first frame after reset reads 1). It wraps 65535→0 and holds when en=0.
- Undefined: frame_cnt is tied to 0 and no counter logic is generated.

Test Plan:
- Reset release, en=1: first edge gives sx=0, sy=0, de=1, frame=1, line=1, hsync=vsync=1 (SYNC_POL=0); next edge gives sx=1, frame=0, line=0.
- Free run one line: de=1 for exactly 640 clocks; hsync=0 for exactly 96 clocks starting at sx=656; line period = 800 clocks.
- Free run two frames: frame strobe period = 420000 clocks; vsync=0 for exactly 1600 clocks starting at (sx=0, sy=490); sy wraps 524→0 in the same cycle sx wraps 799→0.
- PIPE_DLY=2: de_d/hsync_d/vsync_d equal de/hsync/vsync from 2 clocks earlier across a full line; PIPE_DLY=0 gives identical signals.
- en=0 for 10 clocks at sx=300, sy=100: sx, sy, de and the delay line hold; on en=1 the count resumes at sx=301 with no skipped or repeated values.
- With TIMING_480P_FRAME_CNT_EN, run 3 frames, then assert rst_n=0 mid-line: frame_cnt reads 1, 2, 3 at successive frame strobes; during reset sx=799, sy=524, de=0, frame_cnt=0.
